// File: rtl/float_to_fixed_stream.sv
// float_to_fixed_stream: IEEE-754 single -> signed fixed point (1+INTS+FRACS bits), 2-stage valid/ready pipeline.
// Define FLOAT_TO_FIXED_ROUND_EN for round-to-nearest-even on right shifts instead of truncation.
module float_to_fixed_stream #(
    parameter int INTS  = 1,
    parameter int FRACS = 22
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         in_float,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [INTS+FRACS:0] out_fixed,
    output logic [2:0]          out_flags,
    output logic                out_valid,
    input  logic                out_ready
);
    localparam int OUT_W = 1 + INTS + FRACS;
    localparam int MW    = OUT_W + 25;
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic             w_s1_adv, w_s2_adv;
    logic [7:0]       w_e;
    logic             r_s1_valid, r_s1_sign, r_s1_zero, r_s1_den, r_s1_inf, r_s1_nan, r_s1_big, r_s1_min;
    logic [22:0]      r_s1_man;
    logic [9:0]       r_s1_sh;
    logic [9:0]       w_k;
    logic [4:0]       w_kc;
    logic [23:0]      w_kept;
    logic             w_rnd, w_cov, w_sat;
    logic [MW-1:0]    w_lmag, w_mag;
    logic [OUT_W-1:0] w_res, w_fix;
    logic [2:0]       w_flg;
    logic [OUT_W-1:0] r_out_fixed;
    logic [2:0]       r_out_flags;
    logic             r_out_valid;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_e      = in_float[30:23];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_man   <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_den   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_sh    <= '0;
            r_s1_big   <= 1'b0;
            r_s1_min   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= in_float[31];
            r_s1_man   <= in_float[22:0];
            r_s1_zero  <= w_e == 8'd0 && in_float[22:0] == '0;
            r_s1_den   <= w_e == 8'd0 && in_float[22:0] != '0;
            r_s1_inf   <= w_e == 8'hFF && in_float[22:0] == '0;
            r_s1_nan   <= w_e == 8'hFF && in_float[22:0] != '0;
            r_s1_sh    <= 10'(int'(w_e) - 150 + FRACS);
            r_s1_big   <= int'(w_e) - 127 >= INTS;
            r_s1_min   <= in_float[31] && int'(w_e) == 127 + INTS && in_float[22:0] == '0;
        end
    end

    // Right-shift distance saturates at 25: every mantissa bit, guard included, is gone by then.
    assign w_k    = -r_s1_sh;
    assign w_kc   = r_s1_sh[9] ? (w_k > 10'd25 ? 5'd25 : w_k[4:0]) : 5'd0;
    assign w_lmag = MW'({1'b1, r_s1_man}) << r_s1_sh[8:0];

`ifdef FLOAT_TO_FIXED_ROUND_EN
    logic [48:0] w_rsh;
    assign w_rsh  = {1'b1, r_s1_man, 25'b0} >> w_kc;
    assign w_kept = w_rsh[48:25];
    assign w_rnd  = w_rsh[24] && (|w_rsh[23:0] || w_rsh[25]);
    assign w_cov  = w_mag > MW'(SAT_POS) + MW'(r_s1_sign);
`else
    assign w_kept = {1'b1, r_s1_man} >> w_kc;
    assign w_rnd  = 1'b0;
    assign w_cov  = 1'b0;
`endif

    assign w_mag = r_s1_sh[9] ? MW'(w_kept) + MW'(w_rnd) : w_lmag;
    assign w_res = r_s1_sign ? OUT_W'(-w_mag) : OUT_W'(w_mag);
    assign w_sat = r_s1_inf || (r_s1_big && !r_s1_min) || w_cov;
    assign w_fix = (r_s1_nan || r_s1_zero || r_s1_den) ? '0 :
                   r_s1_min ? SAT_NEG :
                   w_sat ? (r_s1_sign ? SAT_NEG : SAT_POS) : w_res;
    assign w_flg = {r_s1_nan, w_sat && !r_s1_nan, !r_s1_zero && !r_s1_big && !w_cov && w_mag == '0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_fixed <= '0;
            r_out_flags <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            r_out_fixed <= w_fix;
            r_out_flags <= w_flg;
        end
    end

    assign out_valid = r_out_valid;
    assign out_fixed = r_out_fixed;
    assign out_flags = r_out_flags;
endmodule

// File: tb/tb_float_to_fixed_stream.sv
// tb_float_to_fixed_stream: directed vectors checked against a real-arithmetic reference model,
// a scoreboard with stall/flow-control checks, and literal expectations.
module tb_float_to_fixed_stream;
    localparam int INTS = 1, FRACS = 22, W = 1 + INTS + FRACS;

`ifdef FLOAT_TO_FIXED_ROUND_EN
    localparam logic [W+2:0] X03 = {24'h400002, 3'b000};
    localparam logic [W+2:0] X44 = {24'h000001, 3'b000};
    localparam logic [W+2:0] XFF = {24'h7FFFFF, 3'b010};
`else
    localparam logic [W+2:0] X03 = {24'h400001, 3'b000};
    localparam logic [W+2:0] X44 = {24'h000000, 3'b001};
    localparam logic [W+2:0] XFF = {24'h7FFFFF, 3'b000};
`endif

    logic         clk = 0, reset_n = 1, in_valid = 0, out_ready = 1, lat_chk = 0;
    logic         in_ready, out_valid;
    logic [31:0]  in_float = 0;
    logic [W-1:0] out_fixed;
    logic [2:0]   out_flags;
    int           tests = 0, fails = 0, cyc = 0;
    logic [W+2:0] exp_q[$];
    int           acc_q[$];
    logic         held = 0;
    logic [W-1:0] h_fix;
    logic [2:0]   h_flg;
    logic [31:0]  sv [6] = '{32'h3F800000, 32'hBF000000, 32'h40400000, 32'h7FC00000, 32'h3E800000, 32'hBFC00000};

    float_to_fixed_stream #(.INTS(INTS), .FRACS(FRACS)) dut (
        .clk(clk), .reset_n(reset_n), .in_float(in_float), .in_valid(in_valid), .in_ready(in_ready),
        .out_fixed(out_fixed), .out_flags(out_flags), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Exact value of the float scaled by 2^FRACS, then truncated or rounded, then range-checked.
    function automatic logic [W+2:0] model(input logic [31:0] f);
        int     e;
        real    mag, t, lim;
        longint q;
        e   = int'(f[30:23]);
        lim = 2.0 ** real'(INTS + FRACS);
        if (e == 255) return (f[22:0] != 0) ? {{W{1'b0}}, 3'b100} : {f[31], {(W-1){!f[31]}}, 3'b010};
        if (e == 0) return {{W{1'b0}}, 2'b00, f[22:0] != 0};
        mag = (1.0 + real'(f[22:0]) / 8388608.0) * 2.0 ** real'(e - 127 + FRACS);
        t   = $floor(mag);
`ifdef FLOAT_TO_FIXED_ROUND_EN
        if (mag - t > 0.5 || (mag - t == 0.5 && t / 2.0 != $floor(t / 2.0))) t = t + 1.0;
`endif
        if (t > lim - (f[31] ? 0.0 : 1.0)) return {f[31], {(W-1){!f[31]}}, 3'b010};
        if (t == 0.0) return {{W{1'b0}}, 3'b001};
        q = longint'(t);
        if (f[31]) q = -q;
        return {W'(q), 3'b000};
    endfunction

    initial begin
        logic [W+2:0] ex;
        int a;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                exp_q.delete();
                acc_q.delete();
                held = 0;
            end else begin
                tests++;
                if (in_ready !== (exp_q.size() < 2 || out_ready)) begin
                    fails++;
                    $display("FAIL in_ready: got %b want %b (in flight %0d)", in_ready, exp_q.size() < 2 || out_ready, exp_q.size());
                end
                if (held) begin
                    tests++;
                    if (!out_valid || out_fixed !== h_fix || out_flags !== h_flg) begin
                        fails++;
                        $display("FAIL stall_hold: got %b/%h/%b want 1/%h/%b", out_valid, out_fixed, out_flags, h_fix, h_flg);
                    end
                end
                if (out_valid && exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %h/%b with nothing in flight", out_fixed, out_flags);
                end else if (out_valid && out_ready) begin
                    ex = exp_q.pop_front();
                    a  = acc_q.pop_front();
                    tests++;
                    if ({out_fixed, out_flags} !== ex) begin
                        fails++;
                        $display("FAIL model: got %h/%b want %h/%b", out_fixed, out_flags, ex[W+2:3], ex[2:0]);
                    end
                    if (lat_chk) begin
                        tests++;
                        if (cyc - a != 2) begin
                            fails++;
                            $display("FAIL latency: got %0d cycles want 2", cyc - a);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_float));
                    acc_q.push_back(cyc);
                end
                held  = out_valid && !out_ready;
                h_fix = out_fixed;
                h_flg = out_flags;
            end
        end
    end

    task automatic one(input logic [31:0] f, input logic [W-1:0] xf, input logic [2:0] xl, input string nm);
        int n;
        @(posedge clk);
        #1;
        in_float = f;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!out_valid || out_fixed !== xf || out_flags !== xl) begin
            fails++;
            $display("FAIL %s: in=%h got %h flags %b valid %b, want %h flags %b", nm, f, out_fixed, out_flags, out_valid, xf, xl);
        end
    endtask

    initial begin
        int n;
        #1 reset_n = 0;
        #10;
        tests++;
        if (out_valid !== 0 || out_fixed !== 0 || out_flags !== 0 || in_ready !== 1) begin
            fails++;
            $display("FAIL reset: got v=%b fx=%h fl=%b rdy=%b want 0/0/0/1", out_valid, out_fixed, out_flags, in_ready);
        end
        #6 reset_n = 1;
        lat_chk = 1;
        one(32'h3F800000, 24'h400000, 3'b000, "one");
        one(32'hBF000000, 24'hE00000, 3'b000, "neg_half");
        one(32'hBF800000, 24'hC00000, 3'b000, "neg_one");
        one(32'h40400000, 24'h7FFFFF, 3'b010, "three_sat");
        one(32'h40000000, 24'h7FFFFF, 3'b010, "pos_two_sat");
        one(32'hC0000000, 24'h800000, 3'b000, "neg_two_exact");
        one(32'hFF800000, 24'h800000, 3'b010, "neg_inf");
        one(32'h7F800000, 24'h7FFFFF, 3'b010, "pos_inf");
        one(32'h7FC00000, 24'h000000, 3'b100, "nan");
        one(32'h2EDBE6FF, 24'h000000, 3'b001, "tiny_unf");
        one(32'h00000001, 24'h000000, 3'b001, "denormal");
        one(32'h80000000, 24'h000000, 3'b000, "neg_zero");
        one(32'h34800000, 24'h000001, 3'b000, "lsb");
        one(32'h34000000, 24'h000000, 3'b001, "half_lsb");
        one(32'h3F800001, 24'h400000, 3'b000, "tie_even");
        one(32'h3F800003, X03[W+2:3], X03[2:0], "round_up");
        one(32'h34400000, X44[W+2:3], X44[2:0], "frac_lsb");
        one(32'h3FFFFFFF, XFF[W+2:3], XFF[2:0], "near_two");
        lat_chk = 0;

        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    in_float = sv[i];
                    in_valid = 1;
                    n = 0;
                    @(negedge clk);
                    while (!in_ready && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!in_ready) begin
                        tests++;
                        fails++;
                        $display("FAIL stream_accept: sample %0d never accepted", i);
                    end
                    @(posedge clk);
                    #1;
                end
                in_valid = 0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 0;
                @(negedge clk);
                tests++;
                if (in_ready !== 0) begin
                    fails++;
                    $display("FAIL stall_ready: got %b want 0", in_ready);
                end
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL stream_drain: got %0d left want 0", exp_q.size());
        end

        out_ready = 0;
        in_float  = 32'h3F800000;
        in_valid  = 1;
        @(posedge clk);
        #1;
        in_float = 32'h40400000;
        @(posedge clk);
        #1;
        in_valid = 0;
        tests++;
        if (out_valid !== 1) begin
            fails++;
            $display("FAIL inflight: got out_valid %b want 1", out_valid);
        end
        #1 reset_n = 0;
        #1;
        tests++;
        if (out_valid !== 0 || out_fixed !== 0 || out_flags !== 0) begin
            fails++;
            $display("FAIL async_reset: got v=%b fx=%h fl=%b want 0/0/0", out_valid, out_fixed, out_flags);
        end
        #10 reset_n = 1;
        out_ready = 1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1) begin
            fails++;
            $display("FAIL post_reset_ready: got %b want 1", in_ready);
        end
        repeat (3) @(negedge clk);
        one(32'hBF000000, 24'hE00000, 3'b000, "post_reset");
        repeat (5) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL final_drain: got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
